// File: rtl/uart_modport_if.sv
// uart_modport_if: parallel byte handshake between a CSR front-end and the
// UART core.
//   tx_data_i/tx_valid_i  : byte offered by the front-end
//   tx_ready_o            : core accepts the byte when valid & ready
//   rx_data_o             : last received byte
//   rx_valid_o            : one-cycle pulse, rx_data_o is new
//   rx_frame_err_o        : pulse with rx_valid_o, stop bit was 0
//   rx_parity_err_o       : pulse with rx_valid_o, parity mismatch
// master = front-end side, slave = UART core side.
interface uart_modport_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_frame_err_o;
  logic       rx_parity_err_o;

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, rx_frame_err_o, rx_parity_err_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, rx_data_o, rx_valid_o, rx_frame_err_o, rx_parity_err_o
  );
endinterface

// File: rtl/uart_modport.sv
// uart_modport: single-channel UART core, 8 data bits, optional parity,
// one stop bit, OVERSAMPLE ticks per bit from a programmable clock divider.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   baud_div_i           : clocks per oversample tick (0 behaves as 1)
//   tx_en_i, rx_en_i     : transmitter / receiver enables
//   parity_en_i          : append / check a parity bit
//   parity_odd_i         : 1 = odd parity, 0 = even
//   tx_idle_o, rx_idle_o : no tx frame in flight / rx waiting for start bit
//   uart_rx_i            : serial input (idle high)
//   uart_tx_o            : serial output (idle high)
//   uart_tx_en_o         : pad output enable
//   bus                  : byte handshake (uart_modport_if.slave)
module uart_modport #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             tx_en_i,
  input  logic             rx_en_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  output logic             tx_idle_o,
  output logic             rx_idle_o,
  input  logic             uart_rx_i,
  output logic             uart_tx_o,
  output logic             uart_tx_en_o,
  uart_modport_if.slave    bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // Three vote samples straddle the bit centre (7, 8, 9 for 16x).
  localparam logic [TW-1:0] SMP_A = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] SMP_B = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] SMP_C = TW'(OVERSAMPLE / 2 + 1);

  logic [DIV_W-1:0] div_last;
  assign div_last = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);

  // ------------------------------------------------------------ transmitter
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t        tx_state_reg, tx_state_next;
  logic [DIV_W-1:0] tx_div_cnt_reg;
  logic [TW-1:0]    tx_tick_cnt_reg;
  logic [7:0]       tx_shift_reg, tx_shift_next;
  logic [2:0]       tx_bit_reg, tx_bit_next;
  logic             tx_line_reg, tx_line_next;
  logic             tx_par_en_reg, tx_par_en_next;
  logic             tx_par_bit_reg, tx_par_bit_next;
  logic             tx_oe_reg, armed_reg;
  logic             tx_tick, tx_bit_done, tx_ready, tx_accept;

  // armed_reg keeps ready low while reset is held and for one clock after.
  assign tx_ready    = armed_reg & tx_en_i & (tx_state_reg == TX_IDLE);
  assign tx_accept   = tx_ready & bus.tx_valid_i;
  assign tx_tick     = (tx_div_cnt_reg >= div_last);
  assign tx_bit_done = tx_tick & (tx_tick_cnt_reg == TICK_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_reg    <= TX_IDLE;
      tx_div_cnt_reg  <= '0;
      tx_tick_cnt_reg <= '0;
      tx_shift_reg    <= '0;
      tx_bit_reg      <= '0;
      tx_line_reg     <= 1'b1;
      tx_par_en_reg   <= 1'b0;
      tx_par_bit_reg  <= 1'b0;
      tx_oe_reg       <= 1'b0;
      armed_reg       <= 1'b0;
    end else begin
      tx_state_reg   <= tx_state_next;
      tx_shift_reg   <= tx_shift_next;
      tx_bit_reg     <= tx_bit_next;
      tx_line_reg    <= tx_line_next;
      tx_par_en_reg  <= tx_par_en_next;
      tx_par_bit_reg <= tx_par_bit_next;
      tx_oe_reg      <= tx_en_i | (tx_state_reg != TX_IDLE);
      armed_reg      <= 1'b1;
      // Restarting the divider on acceptance aligns bit edges to it.
      tx_div_cnt_reg <= (tx_accept || tx_tick) ? '0 : tx_div_cnt_reg + DIV_W'(1);
      if (tx_accept) tx_tick_cnt_reg <= '0;
      else if (tx_tick) tx_tick_cnt_reg <= tx_tick_cnt_reg + TW'(1);
    end
  end

  always_comb begin
    tx_state_next   = tx_state_reg;
    tx_shift_next   = tx_shift_reg;
    tx_bit_next     = tx_bit_reg;
    tx_line_next    = tx_line_reg;
    tx_par_en_next  = tx_par_en_reg;
    tx_par_bit_next = tx_par_bit_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_line_next = 1'b1;
        if (tx_accept) begin
          tx_state_next   = TX_START;
          tx_shift_next   = bus.tx_data_i;
          tx_line_next    = 1'b0;
          tx_par_en_next  = parity_en_i;
          tx_par_bit_next = (^bus.tx_data_i) ^ parity_odd_i;
        end
      end
      TX_START: if (tx_bit_done) begin
        tx_state_next = TX_DATA;
        tx_bit_next   = '0;
        tx_line_next  = tx_shift_reg[0];
      end
      TX_DATA: if (tx_bit_done) begin
        if (tx_bit_reg == 3'd7) begin
          tx_state_next = tx_par_en_reg ? TX_PARITY : TX_STOP;
          tx_line_next  = tx_par_en_reg ? tx_par_bit_reg : 1'b1;
        end else begin
          tx_bit_next   = tx_bit_reg + 3'd1;
          tx_shift_next = {1'b0, tx_shift_reg[7:1]};
          tx_line_next  = tx_shift_reg[1];
        end
      end
      TX_PARITY: if (tx_bit_done) begin
        tx_state_next = TX_STOP;
        tx_line_next  = 1'b1;
      end
      TX_STOP: if (tx_bit_done) tx_state_next = TX_IDLE;
      default: begin
        tx_state_next = TX_IDLE;
        tx_line_next  = 1'b1;
      end
    endcase
  end

  assign bus.tx_ready_o = tx_ready;
  assign tx_idle_o      = (tx_state_reg == TX_IDLE);
  assign uart_tx_o      = tx_line_reg;
  assign uart_tx_en_o   = tx_oe_reg;

  // --------------------------------------------------------------- receiver
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  rx_state_t        rx_state_reg, rx_state_next;
  logic [1:0]       rx_sync_reg;
  logic             rx_prev_reg;
  logic [DIV_W-1:0] rx_div_cnt_reg;
  logic [TW-1:0]    rx_tick_cnt_reg;
  logic [1:0]       rx_smp_reg;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic             rx_par_en_reg, rx_par_en_next, rx_par_odd_reg, rx_par_odd_next;
  logic             rx_perr_pend_reg, rx_perr_pend_next;
  logic [7:0]       rx_data_reg, rx_data_next;
  logic             rx_valid_reg, rx_valid_next;
  logic             rx_ferr_reg, rx_ferr_next, rx_perr_reg, rx_perr_next;
  logic             rx_line, rx_start, rx_tick, rx_vote_stb, rx_vote;

  assign rx_line     = rx_sync_reg[1];
  assign rx_start    = rx_en_i & (rx_state_reg == RX_IDLE) & rx_prev_reg & ~rx_line;
  assign rx_tick     = (rx_div_cnt_reg >= div_last);
  assign rx_vote_stb = rx_tick & (rx_tick_cnt_reg == SMP_C);
  // Majority of the two stored samples and the one taken right now.
  assign rx_vote = (rx_smp_reg[0] & rx_smp_reg[1]) | (rx_smp_reg[0] & rx_line) |
                   (rx_smp_reg[1] & rx_line);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_reg     <= RX_IDLE;
      rx_sync_reg      <= 2'b11;
      rx_prev_reg      <= 1'b1;
      rx_div_cnt_reg   <= '0;
      rx_tick_cnt_reg  <= '0;
      rx_smp_reg       <= 2'b11;
      rx_shift_reg     <= '0;
      rx_bit_reg       <= '0;
      rx_par_en_reg    <= 1'b0;
      rx_par_odd_reg   <= 1'b0;
      rx_perr_pend_reg <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_ferr_reg      <= 1'b0;
      rx_perr_reg      <= 1'b0;
    end else begin
      rx_state_reg     <= rx_state_next;
      rx_sync_reg      <= {rx_sync_reg[0], uart_rx_i};
      rx_prev_reg      <= rx_line;
      rx_shift_reg     <= rx_shift_next;
      rx_bit_reg       <= rx_bit_next;
      rx_par_en_reg    <= rx_par_en_next;
      rx_par_odd_reg   <= rx_par_odd_next;
      rx_perr_pend_reg <= rx_perr_pend_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rx_ferr_reg      <= rx_ferr_next;
      rx_perr_reg      <= rx_perr_next;
      // Receiver bit timing is anchored to the detected start edge.
      rx_div_cnt_reg <= (rx_start || rx_tick) ? '0 : rx_div_cnt_reg + DIV_W'(1);
      if (rx_start) rx_tick_cnt_reg <= '0;
      else if (rx_tick) rx_tick_cnt_reg <= rx_tick_cnt_reg + TW'(1);
      if (rx_tick && rx_tick_cnt_reg == SMP_A) rx_smp_reg[0] <= rx_line;
      if (rx_tick && rx_tick_cnt_reg == SMP_B) rx_smp_reg[1] <= rx_line;
    end
  end

  always_comb begin
    rx_state_next     = rx_state_reg;
    rx_shift_next     = rx_shift_reg;
    rx_bit_next       = rx_bit_reg;
    rx_par_en_next    = rx_par_en_reg;
    rx_par_odd_next   = rx_par_odd_reg;
    rx_perr_pend_next = rx_perr_pend_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rx_ferr_next      = 1'b0;
    rx_perr_next      = 1'b0;
    if (!rx_en_i) begin
      rx_state_next = RX_IDLE;
    end else begin
      case (rx_state_reg)
        RX_IDLE: if (rx_start) begin
          rx_state_next     = RX_START;
          rx_par_en_next    = parity_en_i;
          rx_par_odd_next   = parity_odd_i;
          rx_perr_pend_next = 1'b0;
        end
        RX_START: if (rx_vote_stb) begin
          rx_state_next = rx_vote ? RX_IDLE : RX_DATA;  // high vote = glitch
          rx_bit_next   = '0;
        end
        RX_DATA: if (rx_vote_stb) begin
          rx_shift_next = {rx_vote, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = rx_par_en_reg ? RX_PARITY : RX_STOP;
        end
        RX_PARITY: if (rx_vote_stb) begin
          rx_perr_pend_next = rx_vote ^ (^rx_shift_reg) ^ rx_par_odd_reg;
          rx_state_next     = RX_STOP;
        end
        RX_STOP: if (rx_vote_stb) begin
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          rx_ferr_next  = ~rx_vote;
          rx_perr_next  = rx_par_en_reg & rx_perr_pend_reg;
          // Leave mid stop bit so a following start edge is not missed.
          rx_state_next = rx_vote ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (rx_line) rx_state_next = RX_IDLE;
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

  assign rx_idle_o           = (rx_state_reg == RX_IDLE);
  assign bus.rx_data_o       = rx_data_reg;
  assign bus.rx_valid_o      = rx_valid_reg;
  assign bus.rx_frame_err_o  = rx_ferr_reg;
  assign bus.rx_parity_err_o = rx_perr_reg;
endmodule

// File: tb/tb_uart_modport.sv
// tb_uart_modport: directed and randomized checks of uart_modport against a
// frame-level model (bit lists built from data/parity rules, byte queues).
module tb_uart_modport;
  logic        clk;
  logic        rst_n;
  logic [15:0] baud_div;
  logic        tx_en, rx_en, par_en, par_odd;
  logic        tx_idle, rx_idle, uart_tx, uart_tx_en;
  logic        rx_drive, loop_en, rx_line;
  int          tests;
  int          fails;
  logic [9:0]  rxq[$];  // {frame_err, parity_err, data}

  uart_modport_if bus();

  assign rx_line = loop_en ? uart_tx : rx_drive;

  uart_modport #(.OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .baud_div_i(baud_div),
    .tx_en_i(tx_en), .rx_en_i(rx_en), .parity_en_i(par_en), .parity_odd_i(par_odd),
    .tx_idle_o(tx_idle), .rx_idle_o(rx_idle),
    .uart_rx_i(rx_line), .uart_tx_o(uart_tx), .uart_tx_en_o(uart_tx_en),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect every received byte; duplicated pulses show up as extra entries.
  always @(negedge clk)
    if (bus.rx_valid_o)
      rxq.push_back({bus.rx_frame_err_o, bus.rx_parity_err_o, bus.rx_data_o});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Send one byte on the tx side and check its waveform bit by bit.
  task automatic tx_frame_check(input logic [7:0] d, input logic pe, input logic po, input int div);
    int   eff, nbits, bitlen, low, w;
    logic seen_high;
    logic exp_bits[11];
    eff    = (div == 0) ? 1 : div;
    nbits  = pe ? 11 : 10;
    bitlen = 16 * eff;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
    exp_bits[9]  = pe ? ((^d) ^ po) : 1'b1;
    exp_bits[10] = 1'b1;
    baud_div = 16'(div); par_en = pe; par_odd = po;
    w = 0;
    while (!bus.tx_ready_o && w < 5000) begin @(negedge clk); w++; end
    check("tx_ready_before", {31'd0, bus.tx_ready_o}, 1);
    bus.tx_data_i = d; bus.tx_valid_i = 1'b1;
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
    low = 0; seen_high = 1'b0;
    for (int n = 1; n <= nbits * bitlen + 8; n++) begin
      if (((n - 1) % bitlen) == bitlen / 2 && ((n - 1) / bitlen) < nbits)
        check($sformatf("tx_bit%0d_d%0h", (n - 1) / bitlen, d), {31'd0, uart_tx}, {31'd0, exp_bits[(n - 1) / bitlen]});
      if (!seen_high) begin
        if (!bus.tx_ready_o) low++;
        else seen_high = 1'b1;
      end
      @(negedge clk);
    end
    check("tx_ready_low_clocks", low, nbits * bitlen);
    check("tx_idle_after", {31'd0, tx_idle}, 1);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int w;
    w = 0;
    bus.tx_data_i = d; bus.tx_valid_i = 1'b1;
    while (!bus.tx_ready_o && w < 5000) begin @(negedge clk); w++; end
    check("push_ready", {31'd0, bus.tx_ready_o}, 1);
    @(negedge clk);
    bus.tx_valid_i = 1'b0;
  endtask

  // Drive one frame onto the rx line; gbit >= 0 inverts one tick mid bit.
  task automatic drive_rx(input logic [7:0] d, input logic pe, input logic pbit,
                          input logic stop, input int div, input int gbit);
    int   eff, nbits;
    logic bits[11];
    eff   = (div == 0) ? 1 : div;
    nbits = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = pe ? pbit : stop;
    bits[10] = stop;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < 16 * eff; c++) begin
        rx_drive = bits[b] ^ (b == gbit && c >= 8 * eff && c < 9 * eff);
        @(negedge clk);
      end
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic fe, input logic pe);
    logic [9:0] e;
    check("rx_present", {31'd0, rxq.size() > 0}, 1);
    if (rxq.size() > 0) begin
      e = rxq.pop_front();
      check("rx_data", {24'd0, e[7:0]}, {24'd0, d});
      check("rx_frame_err", {31'd0, e[9]}, {31'd0, fe});
      check("rx_parity_err", {31'd0, e[8]}, {31'd0, pe});
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       pe, po, pbit, good;
    int         div, w;
    tests = 0; fails = 0;
    rst_n = 1'b0; tx_en = 1'b1; rx_en = 1'b1; baud_div = 16'd4;
    par_en = 1'b0; par_odd = 1'b0; rx_drive = 1'b1; loop_en = 1'b0;
    bus.tx_data_i = 8'h00; bus.tx_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'd0, uart_tx}, 1);
    check("rst_tx_pad_en", {31'd0, uart_tx_en}, 0);
    check("rst_tx_ready", {31'd0, bus.tx_ready_o}, 0);
    check("rst_rx_valid", {31'd0, bus.rx_valid_o}, 0);
    check("rst_ferr", {31'd0, bus.rx_frame_err_o}, 0);
    check("rst_perr", {31'd0, bus.rx_parity_err_o}, 0);
    check("rst_rx_data", {24'd0, bus.rx_data_o}, 0);
    check("rst_tx_idle", {31'd0, tx_idle}, 1);
    check("rst_rx_idle", {31'd0, rx_idle}, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("tx_pad_en_on", {31'd0, uart_tx_en}, 1);

    // Directed and random tx waveforms, including divider 0.
    tx_frame_check(8'hA5, 1'b0, 1'b0, 4);
    tx_frame_check(8'h3E, 1'b1, 1'b1, 0);
    for (int k = 0; k < 2; k++)
      tx_frame_check(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(1, 3)));

    // Loopback, even parity, back-to-back.
    baud_div = 16'd2; par_en = 1'b1; par_odd = 1'b0; loop_en = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(8'h3C);
    push_tx(8'hFF);
    w = 0;
    while (rxq.size() < 2 && w < 5000) begin @(negedge clk); w++; end
    repeat (40) @(negedge clk);
    check("loop_count", rxq.size(), 2);
    expect_rx(8'h3C, 1'b0, 1'b0);
    expect_rx(8'hFF, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom); par_en = 1'($urandom); par_odd = 1'($urandom);
      baud_div = 16'($urandom_range(1, 3));
      push_tx(d);
      w = 0;
      while (rxq.size() < 1 && w < 5000) begin @(negedge clk); w++; end
      repeat (60) @(negedge clk);
      check("loop_rand_count", rxq.size(), 1);
      expect_rx(d, 1'b0, 1'b0);
    end
    loop_en = 1'b0; rx_drive = 1'b1;
    repeat (50) @(negedge clk);

    // Stop bit 0: byte delivered with frame error, then BREAK until high.
    baud_div = 16'd2; par_en = 1'b0;
    drive_rx(8'h55, 1'b0, 1'b0, 1'b0, 2, -1);
    repeat (64) @(negedge clk);
    check("break_count", rxq.size(), 1);
    check("break_not_idle", {31'd0, rx_idle}, 0);
    expect_rx(8'h55, 1'b1, 1'b0);
    rx_drive = 1'b1;
    repeat (32) @(negedge clk);
    check("break_rearmed", {31'd0, rx_idle}, 1);
    drive_rx(8'h12, 1'b0, 1'b0, 1'b1, 2, -1);
    repeat (8) @(negedge clk);
    expect_rx(8'h12, 1'b0, 1'b0);

    // Odd parity, wrong parity bit.
    par_en = 1'b1; par_odd = 1'b1;
    drive_rx(8'h01, 1'b1, 1'b1, 1'b1, 2, -1);
    repeat (8) @(negedge clk);
    expect_rx(8'h01, 1'b0, 1'b1);

    // Random rx frames with random parity correctness.
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom); pe = 1'($urandom); po = 1'($urandom); good = 1'($urandom);
      div = int'($urandom_range(1, 3));
      par_en = pe; par_odd = po; baud_div = 16'(div);
      pbit = (^d) ^ po ^ ~good;
      repeat (20) @(negedge clk);
      drive_rx(d, pe, pbit, 1'b1, div, -1);
      repeat (8) @(negedge clk);
      expect_rx(d, 1'b0, pe & ~good);
    end

    // Glitch rejection.
    baud_div = 16'd2; par_en = 1'b0;
    repeat (20) @(negedge clk);
    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    rx_drive = 1'b1;
    repeat (32) @(negedge clk);
    check("glitch_idle", {31'd0, rx_idle}, 1);
    check("glitch_no_byte", rxq.size(), 0);
    drive_rx(8'hA5, 1'b0, 1'b0, 1'b1, 2, 3);
    repeat (8) @(negedge clk);
    expect_rx(8'hA5, 1'b0, 1'b0);

    // Reset in the middle of a tx frame.
    baud_div = 16'd4;
    push_tx(8'h5A);
    repeat (100) @(negedge clk);
    check("midframe_low", {31'd0, tx_idle}, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_uart_tx", {31'd0, uart_tx}, 1);
    check("rst_mid_tx_ready", {31'd0, bus.tx_ready_o}, 0);
    check("rst_mid_tx_idle", {31'd0, tx_idle}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", {31'd0, bus.tx_ready_o}, 1);
    tx_en = 1'b0;
    #1;
    check("tx_dis_ready", {31'd0, bus.tx_ready_o}, 0);
    repeat (2) @(negedge clk);
    check("tx_dis_pad_en", {31'd0, uart_tx_en}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_modport.md
Name: uart_modport

Overview:
- Single-channel UART core: serializes bytes onto the uart_tx line and deserializes bytes from the uart_rx line.
- Frame format is 8N1 or 8 data bits + parity + 1 stop bit.
- Uses 16x oversampling from a programmable divider; the receiver rejects line glitches.
- Sits between a register/CSR front-end (parallel byte handshake) and the chip UART pads; the tx pad is driven tri-state via uart_tx_en_o.

Parameters:
- OVERSAMPLE, 16, ticks per bit; fixed, must be a power of two ≥ 8.
- DIV_W, 16, width of the baud divider input.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- baud_div_i  in  DIV_W  clk cycles per oversample tick; 0 treated as 1
- tx_en_i  in  1  transmitter enable
- rx_en_i  in  1  receiver enable
- parity_en_i  in  1  append/check parity bit
- parity_odd_i  in  1  1 = odd parity, 0 = even
- tx_data_i  in  8  byte to send
- tx_valid_i  in  1  tx byte valid
- tx_ready_o  out  1  tx byte accepted when valid & ready
- rx_data_o  out  8  last received byte
- rx_valid_o  out  1  one-cycle pulse, rx_data_o new
- rx_frame_err_o  out  1  one-cycle pulse with rx_valid_o, stop bit was 0
- rx_parity_err_o  out  1  one-cycle pulse with rx_valid_o, parity mismatch
- tx_idle_o  out  1  transmitter has no frame in flight
- rx_idle_o  out  1  receiver waiting for start bit
- uart_rx_i  in  1  serial input, idle high
- uart_tx_o  out  1  serial output, idle high
- uart_tx_en_o  out  1  pad output enable

Behaviour:
Reset values:
- uart_tx_o=1, uart_tx_en_o=0, tx_ready_o=0, rx_valid_o=0, both error pulses=0, rx_data_o=0, tx_idle_o=1, rx_idle_o=1.
- Divider and all bit/tick counters are 0; the rx synchronizer flops are 1.

Tick generator:
- Free-running counter produces a one-clock tick every max(baud_div_i,1) clocks.
- One bit time = OVERSAMPLE ticks.
- The counter restarts when a tx frame is accepted, so the tx bit edges align to acceptance.
- The receiver uses its own tick counter, restarted on start-bit detection.

Transmitter (states IDLE, START, DATA, PARITY, STOP):
- tx_ready_o = tx_en_i & IDLE.
- On acceptance the byte is latched and uart_tx_o drives 0 (start bit) from the next clock.
- Then 8 data bits LSB first, then parity if parity_en_i, then 1 stop bit (1). Each bit lasts exactly OVERSAMPLE*div clocks.
- Parity = XOR of the data bits, XORed with parity_odd_i.
- After the stop bit: return to IDLE, tx_ready_o rises. Back-to-back frames have no extra idle gap.
- Deasserting tx_en_i mid-frame completes the current frame; no new frame is accepted.
- Parity configuration is sampled at acceptance.
- uart_tx_en_o = tx_en_i | ~tx_idle_o, registered.

Receiver (states IDLE, START, DATA, PARITY, STOP, BREAK):
- uart_rx_i passes through a 2-flop synchronizer.
- IDLE, rx_en_i=1: a synchronized 1→0 transition enters START.
- Each bit value = majority vote of the samples at ticks 7, 8 and 9 of the bit.
- Start bit votes 1: glitch, return to IDLE with no output. A pulse shorter than 3 ticks never produces a byte.
- Data is shifted LSB first, then parity if enabled, then stop.
- At the stop vote: rx_data_o updates and rx_valid_o pulses for 1 clock. rx_frame_err_o pulses if stop=0; rx_parity_err_o pulses on mismatch. Errored bytes are still delivered.
- Stop=1: return to IDLE immediately (supports back-to-back frames).
- Stop=0: go to BREAK and wait until the line is 1 before re-arming.
- Deasserting rx_en_i aborts the frame, returns to IDLE, and produces no output.
- Asynchronous reset mid-frame drops the frame. The first frame after reset needs the line to be high first; the synchronizer reset is 1, so no false start is detected.

Test Plan:
- Reset, div=4, tx 0xA5 no parity → uart_tx_o: 0, 1,0,1,0,0,1,0,1, 1; each bit 64 clocks; tx_ready_o low for 640 clocks.
- Loop uart_tx_o to uart_rx_i, div=2, even parity, send 0x3C then 0xFF back-to-back → rx_valid_o twice with 0x3C and 0xFF, no errors.
- Drive rx 0x55 with stop bit 0 → rx_valid_o with rx_data_o=0x55 and rx_frame_err_o; next byte is accepted only after the line returns high.
- Odd parity, send 0x01 with wrong parity bit (1) → rx_parity_err_o=1, rx_data_o=0x01.
- Low glitch of 2 ticks on an idle rx line → no rx_valid_o, rx_idle_o=1 within 1 bit time; a glitch of 1 tick mid data bit → byte unchanged.
- Assert rst_ni low mid tx frame → uart_tx_o=1 and tx_ready_o=0 immediately; tx_ready_o returns with tx_en_i after release.
